// File: rtl/stall_controller_pkg.sv
// Shared types and encodings for the pipeline stall controller.
// Holds the FPU wait FSM state enum, dispatch-unit encodings,
// the load result-select code and datapath widths.
package stall_controller_pkg;

  localparam int unsigned REG_ADDR_W   = 5;
  localparam int unsigned RESULT_SRC_W = 3;
  localparam int unsigned DU_W         = 4;
  localparam int unsigned PERF_CNT_W   = 32;

  localparam logic [DU_W-1:0] DU_ALU      = 4'b0000;
  localparam logic [DU_W-1:0] DU_FAST_FPU = 4'b0001;
  localparam logic [DU_W-1:0] DU_SLOW_FPU = 4'b0010;
  localparam logic [DU_W-1:0] DU_MEM      = 4'b0011;

  localparam logic [RESULT_SRC_W-1:0] RESULT_SRC_LOAD = 3'b001;

  typedef enum logic [1:0] {
    FPU_IDLE      = 2'd0,
    FPU_FAST_BUSY = 2'd1,
    FPU_SLOW_BUSY = 2'd2,
    FPU_DONE      = 2'd3
  } fpu_state_e;

endpackage

// File: rtl/stall_controller_if.sv
// Hazard/stall signal bundle between the pipeline and the stall controller.
// master: pipeline side (drives hazard sources, receives stall/flush).
// slave : stall controller side.
interface stall_controller_if;
  import stall_controller_pkg::*;

  logic [REG_ADDR_W-1:0]   rs1_d;
  logic [REG_ADDR_W-1:0]   rs2_d;
  logic [REG_ADDR_W-1:0]   rd_e;
  logic [RESULT_SRC_W-1:0] result_src_e;
  logic                    reg_write_e;
  logic                    pc_src_e;
  logic [DU_W-1:0]         dispatch_unit_e;
  logic                    mem_read_m;
  logic                    mem_write_m;
  logic                    cache_data_valid;
  logic                    in_stall;
  logic                    out_stall;
  logic                    fast_fpu_valid;
  logic                    slow_fpu_valid;

  logic stall_f, stall_d, flush_d, stall_e, flush_e, stall_m, flush_m, stall_w;
  logic lw_stall, cache_stall, fast_fpu_en_pulse, slow_fpu_en_pulse;

  modport master (
    output rs1_d, rs2_d, rd_e, result_src_e, reg_write_e, pc_src_e, dispatch_unit_e,
           mem_read_m, mem_write_m, cache_data_valid, in_stall, out_stall,
           fast_fpu_valid, slow_fpu_valid,
    input  stall_f, stall_d, flush_d, stall_e, flush_e, stall_m, flush_m, stall_w,
           lw_stall, cache_stall, fast_fpu_en_pulse, slow_fpu_en_pulse
  );

  modport slave (
    input  rs1_d, rs2_d, rd_e, result_src_e, reg_write_e, pc_src_e, dispatch_unit_e,
           mem_read_m, mem_write_m, cache_data_valid, in_stall, out_stall,
           fast_fpu_valid, slow_fpu_valid,
    output stall_f, stall_d, flush_d, stall_e, flush_e, stall_m, flush_m, stall_w,
           lw_stall, cache_stall, fast_fpu_en_pulse, slow_fpu_en_pulse
  );

endinterface

// File: rtl/stall_controller_fpu_wait_fsm.sv
// FPU wait FSM: tracks an FPU instruction held in E until its result strobe.
// Ports: clk, rst (async active-high), dispatch_unit_e, mem_hold,
//        fast/slow_fpu_valid in; fpu_stall, fast/slow_fpu_en_pulse out.
// The enable pulse is issued in the IDLE cycle the FPU op is seen in E.
module fpu_wait_fsm
  import stall_controller_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [DU_W-1:0] dispatch_unit_e,
  input  logic            mem_hold,
  input  logic            fast_fpu_valid,
  input  logic            slow_fpu_valid,
  output logic            fpu_stall,
  output logic            fast_fpu_en_pulse,
  output logic            slow_fpu_en_pulse
);

  fpu_state_e state_q, state_d;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FPU_IDLE;
    else     state_q <= state_d;
  end

  // Next state; a valid seen while busy is latched into DONE even under mem_hold
  always_comb begin
    state_d = state_q;
    case (state_q)
      FPU_IDLE: begin
        if (!mem_hold) begin
          if (dispatch_unit_e == DU_FAST_FPU)      state_d = FPU_FAST_BUSY;
          else if (dispatch_unit_e == DU_SLOW_FPU) state_d = FPU_SLOW_BUSY;
        end
      end
      FPU_FAST_BUSY: if (fast_fpu_valid) state_d = FPU_DONE;
      FPU_SLOW_BUSY: if (slow_fpu_valid) state_d = FPU_DONE;
      FPU_DONE:      if (!mem_hold)      state_d = FPU_IDLE;
      default:       state_d = FPU_IDLE;
    endcase
  end

  // Outputs: pulses only on the accepting IDLE cycle, suppressed during reset
  always_comb begin
    fast_fpu_en_pulse = 1'b0;
    slow_fpu_en_pulse = 1'b0;
    fpu_stall         = 1'b0;
    if (!mem_hold) begin
      case (state_q)
        FPU_IDLE: begin
          fast_fpu_en_pulse = (dispatch_unit_e == DU_FAST_FPU) && !rst;
          slow_fpu_en_pulse = (dispatch_unit_e == DU_SLOW_FPU) && !rst;
          fpu_stall = (dispatch_unit_e == DU_FAST_FPU) || (dispatch_unit_e == DU_SLOW_FPU);
        end
        FPU_FAST_BUSY, FPU_SLOW_BUSY: fpu_stall = 1'b1;
        default: fpu_stall = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/stall_controller.sv
// Pipeline stall/flush controller: resolves memory hold, FPU wait,
// taken-branch flush and load-use hazards by fixed priority.
// Ports: clk, rst (async active-high), bus (stall_controller_if.slave).
// Optional STALL_CONTROLLER_PERF_CNT_EN adds saturating perf counters
// perf_mem_stall_cnt / perf_fpu_stall_cnt / perf_lw_stall_cnt.
module stall_controller
  import stall_controller_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  stall_controller_if.slave     bus
`ifdef STALL_CONTROLLER_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_mem_stall_cnt,
  output logic [PERF_CNT_W-1:0] perf_fpu_stall_cnt,
  output logic [PERF_CNT_W-1:0] perf_lw_stall_cnt
`endif
);

  logic cache_stall_c, mem_hold_c, lw_hit_c, fpu_stall_c;

  assign cache_stall_c = (bus.mem_read_m | bus.mem_write_m) & ~bus.cache_data_valid;
  assign mem_hold_c    = cache_stall_c | bus.in_stall | bus.out_stall;
  assign lw_hit_c      = bus.reg_write_e & (bus.result_src_e == RESULT_SRC_LOAD) &
                         (bus.rd_e != '0) &
                         ((bus.rd_e == bus.rs1_d) | (bus.rd_e == bus.rs2_d));

  assign bus.cache_stall = cache_stall_c;
  assign bus.lw_stall    = lw_hit_c;

  fpu_wait_fsm u_fpu_wait_fsm (
    .clk               (clk),
    .rst               (rst),
    .dispatch_unit_e   (bus.dispatch_unit_e),
    .mem_hold          (mem_hold_c),
    .fast_fpu_valid    (bus.fast_fpu_valid),
    .slow_fpu_valid    (bus.slow_fpu_valid),
    .fpu_stall         (fpu_stall_c),
    .fast_fpu_en_pulse (bus.fast_fpu_en_pulse),
    .slow_fpu_en_pulse (bus.slow_fpu_en_pulse)
  );

  // Priority: mem_hold > FPU wait > branch flush > load-use
  always_comb begin
    bus.stall_f = 1'b0;
    bus.stall_d = 1'b0;
    bus.flush_d = 1'b0;
    bus.stall_e = 1'b0;
    bus.flush_e = 1'b0;
    bus.stall_m = 1'b0;
    bus.flush_m = 1'b0;
    bus.stall_w = 1'b0;
    if (mem_hold_c) begin
      bus.stall_f = 1'b1;
      bus.stall_d = 1'b1;
      bus.stall_e = 1'b1;
      bus.stall_m = 1'b1;
      bus.stall_w = 1'b1;
    end else if (fpu_stall_c) begin
      bus.stall_f = 1'b1;
      bus.stall_d = 1'b1;
      bus.stall_e = 1'b1;
      bus.flush_m = 1'b1;
    end else if (bus.pc_src_e) begin
      bus.flush_d = 1'b1;
      bus.flush_e = 1'b1;
    end else if (lw_hit_c) begin
      bus.stall_f = 1'b1;
      bus.stall_d = 1'b1;
      bus.flush_e = 1'b1;
    end
  end

`ifdef STALL_CONTROLLER_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] mem_cnt_q, mem_cnt_d;
  logic [PERF_CNT_W-1:0] fpu_cnt_q, fpu_cnt_d;
  logic [PERF_CNT_W-1:0] lw_cnt_q,  lw_cnt_d;
  logic                  lw_win_c;

  assign lw_win_c = lw_hit_c & ~mem_hold_c & ~fpu_stall_c & ~bus.pc_src_e;

  // Saturating increment for whichever cause wins this cycle
  always_comb begin
    mem_cnt_d = mem_cnt_q;
    fpu_cnt_d = fpu_cnt_q;
    lw_cnt_d  = lw_cnt_q;
    if (mem_hold_c && (mem_cnt_q != '1))  mem_cnt_d = mem_cnt_q + PERF_CNT_W'(1);
    if (fpu_stall_c && !mem_hold_c && (fpu_cnt_q != '1)) fpu_cnt_d = fpu_cnt_q + PERF_CNT_W'(1);
    if (lw_win_c && (lw_cnt_q != '1))     lw_cnt_d  = lw_cnt_q + PERF_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_cnt_q <= '0;
      fpu_cnt_q <= '0;
      lw_cnt_q  <= '0;
    end else begin
      mem_cnt_q <= mem_cnt_d;
      fpu_cnt_q <= fpu_cnt_d;
      lw_cnt_q  <= lw_cnt_d;
    end
  end

  assign perf_mem_stall_cnt = mem_cnt_q;
  assign perf_fpu_stall_cnt = fpu_cnt_q;
  assign perf_lw_stall_cnt  = lw_cnt_q;
`endif

endmodule

// File: doc/stall_controller.md
STALL_CONTROLLER -- requirements
Module: stall_controller

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock; rst  in  1  reset, asynchronous, active-high.
REQ-002 SHALL have inputs: rs1_d, rs2_d  in  5 each  decode sources; rd_e  in  5  E destination; result_src_e  in  3  E result select (3'b001 = load); reg_write_e  in  1; pc_src_e  in  1  taken branch/jump in E; dispatch_unit_e  in  4  (4'b0001 fast FPU, 4'b0010 slow FPU).
REQ-003 SHALL have inputs: mem_read_m, mem_write_m  in  1 each; cache_data_valid  in  1; in_stall, out_stall  in  1 each  I/O not ready; fast_fpu_valid, slow_fpu_valid  in  1 each  single-cycle result strobes.
REQ-004 SHALL have outputs, 1 bit each: stall_f, stall_d, flush_d, stall_e, flush_e, stall_m, flush_m, stall_w, lw_stall, cache_stall, fast_fpu_en_pulse, slow_fpu_en_pulse.

Function
REQ-005 SHALL drive cache_stall = (mem_read_m | mem_write_m) & ~cache_data_valid, combinationally.
REQ-006 SHALL define mem_hold = cache_stall | in_stall | out_stall; while mem_hold = 1: stall_f, stall_d, stall_e, stall_m, stall_w = 1; all flushes = 0.
REQ-007 SHALL drive lw_stall = reg_write_e & (result_src_e == 3'b001) & (rd_e != 0) & (rd_e == rs1_d | rd_e == rs2_d); when lw_stall & ~mem_hold: stall_f = stall_d = 1, flush_e = 1.
REQ-008 SHALL run FPU FSM with states IDLE, FAST_BUSY, SLOW_BUSY, DONE.
REQ-009 IDLE: when dispatch_unit_e is fast/slow FPU and ~mem_hold, SHALL assert the matching *_fpu_en_pulse for exactly that cycle and go to FAST_BUSY/SLOW_BUSY; under mem_hold SHALL stay IDLE with no pulse.
REQ-010 FAST_BUSY/SLOW_BUSY: SHALL go to DONE on the cycle the matching valid is 1; the other unit's valid SHALL be ignored; valid in the pulse cycle SHALL be ignored (minimum latency 1).
REQ-011 DONE: SHALL return to IDLE the first cycle ~mem_hold (E advances); a valid strobe arriving under mem_hold is thereby retained.
REQ-012 While an FPU instruction is in E (pulse cycle, *_BUSY) and ~mem_hold: stall_f = stall_d = stall_e = 1, flush_m = 1 (bubble into M); in DONE with ~mem_hold: no FPU stall.
REQ-013 pc_src_e & ~mem_hold & ~FPU stall SHALL assert flush_d = flush_e = 1; stall_f = stall_d = 0 that cycle even if lw_stall.
REQ-014 Priority, highest first: mem_hold, FPU stall, pc_src_e flush, lw_stall; all outputs except the REQ-009 pulses, cache_stall, lw_stall and counters SHALL be combinational from inputs and FSM state.
REQ-015 SHALL guarantee flush_x and stall_x never both 1 for the same stage.

Reset
REQ-016 On rst = 1, FSM SHALL enter IDLE immediately (asynchronous); fast_fpu_en_pulse = slow_fpu_en_pulse = 0 while rst is high.
REQ-017 Reset mid-FPU-operation SHALL abandon the operation; a valid strobe arriving after reset release in IDLE SHALL be ignored.
REQ-018 All other outputs SHALL follow REQ-005..REQ-015 from their inputs during reset (no stored state besides FSM and counters).

Configuration
REQ-019 Macro STALL_CONTROLLER_PERF_CNT_EN defined: SHALL add outputs perf_mem_stall_cnt, perf_fpu_stall_cnt, perf_lw_stall_cnt (out, 32 each), incrementing once per cycle that the corresponding stall source is the winning cause, saturating at 32'hFFFF_FFFF, cleared by rst.
REQ-020 Macro undefined: those ports and registers SHALL not exist; all other behaviour identical.

Structure
REQ-021 Shared package SHALL hold: FPU FSM state enum, dispatch_unit encodings (DU_ALU 4'b0000, DU_FAST_FPU 4'b0001, DU_SLOW_FPU 4'b0010, DU_MEM 4'b0011), RESULT_SRC_LOAD 3'b001.
REQ-022 Sub-module fpu_wait_fsm SHALL implement REQ-008..REQ-012 state/pulse logic; counters stay in top.

Verification
REQ-023 load x5 in E, rs1_d = 5 -> lw_stall = 1, stall_f = stall_d = 1, flush_e = 1 for 1 cycle; rs1_d = 0, rd_e = 0 -> lw_stall = 0.
REQ-024 dispatch_unit_e = 4'b0001, fast_fpu_valid 3 cycles after pulse -> single-cycle pulse, stall_e = 1 for 4 cycles, flush_m = 1 for 4 cycles, then IDLE.
REQ-025 slow FPU busy, slow_fpu_valid while cache_stall = 1 for 5 cycles -> state DONE held, stall_e = 1 until cache_data_valid, then released within 1 cycle, no second pulse.
REQ-026 pc_src_e = 1 with lw_stall = 1 -> flush_d = flush_e = 1, stall_f = 0; same with in_stall = 1 -> all stalls 1, no flush.
REQ-027 rst asserted during FAST_BUSY -> state IDLE next edge-independent, later stray fast_fpu_valid ignored, no pulse without new FPU dispatch.
REQ-028 with STALL_CONTROLLER_PERF_CNT_EN: 7 cache-miss cycles, 2 lw stalls -> perf_mem_stall_cnt = 7, perf_lw_stall_cnt = 2, perf_fpu_stall_cnt = 0.
